// File: rtl/mul_pipe.sv
// -----------------------------------------------------------------------------
// mul_pipe : pipelined WIDTH x WIDTH integer multiplier with a valid/ready
// handshake on both sides.
//
// Each accepted operand pair is multiplied combinationally into stage 1.
// Stages 2..LATENCY only delay the result. The last stage drives the out_*
// ports directly, so every output is a register. A per-transaction mode bit
// selects signed or unsigned arithmetic. A pass-through tag travels with
// each transaction.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst        : synchronous reset, active-high
//   in_valid   : operand pair presented
//   in_ready   : pair can be accepted this cycle (combinational: !stall)
//   in_a/in_b  : multiplicand / multiplier, WIDTH bits
//   in_signed  : 1 = two's-complement operands, 0 = unsigned
//   in_tag     : transaction tag, returned unchanged
//   out_valid  : result present
//   out_ready  : downstream accepts the result
//   out_prod   : full 2*WIDTH product
//   out_tag    : tag of this result
//   out_signed : mode bit of this result
//   inflight   : number of valid entries currently in the pipeline
// -----------------------------------------------------------------------------
module mul_pipe #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 3,
    parameter int TAG_W   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_a,
    input  logic [WIDTH-1:0]               in_b,
    input  logic                           in_signed,
    input  logic [TAG_W-1:0]               in_tag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [2*WIDTH-1:0]             out_prod,
    output logic [TAG_W-1:0]               out_tag,
    output logic                           out_signed,
    output logic [$clog2(LATENCY+1)-1:0]   inflight
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(LATENCY + 1);

    // Pipeline stage registers; index LATENCY-1 is the output stage.
    logic             r_vld  [LATENCY];
    logic [PW-1:0]    r_prod [LATENCY];
    logic [TAG_W-1:0] r_tag  [LATENCY];
    logic             r_sgn  [LATENCY];
    logic [CW-1:0]    r_inflight;

    logic [PW-1:0]    w_a_ext;
    logic [PW-1:0]    w_b_ext;
    logic [PW-1:0]    w_prod;
    logic             w_stall;
    logic             w_accept;
    logic             w_retire;

    // Extending both operands to 2*WIDTH and keeping the low 2*WIDTH bits of
    // the product gives the exact result in both modes. The truncation cannot
    // overflow, because the true product always fits in 2*WIDTH bits.
    assign w_a_ext = in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
    assign w_b_ext = in_signed ? {{WIDTH{in_b[WIDTH-1]}}, in_b} : {{WIDTH{1'b0}}, in_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // The whole pipe freezes only when a valid result is refused downstream.
    // Bubbles are not squeezed out.
    assign w_stall  = r_vld[LATENCY-1] & ~out_ready;
    assign w_accept = in_valid & ~w_stall;
    assign w_retire = r_vld[LATENCY-1] & out_ready;

    assign in_ready   = ~w_stall;
    assign out_valid  = r_vld[LATENCY-1];
    assign out_prod   = r_prod[LATENCY-1];
    assign out_tag    = r_tag[LATENCY-1];
    assign out_signed = r_sgn[LATENCY-1];
    assign inflight   = r_inflight;

    // Stage advance, multiplier capture and in-flight occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_vld[i]  <= 1'b0;
                r_prod[i] <= '0;
                r_tag[i]  <= '0;
                r_sgn[i]  <= 1'b0;
            end
            r_inflight <= '0;
        end else begin
            if (!w_stall) begin
                // Stage 1 loads a bubble when nothing is accepted. Its data
                // is then don't-care, so it is loaded unconditionally.
                r_vld[0]  <= w_accept;
                r_prod[0] <= w_prod;
                r_tag[0]  <= in_tag;
                r_sgn[0]  <= in_signed;
                for (int i = 1; i < LATENCY; i++) begin
                    r_vld[i]  <= r_vld[i-1];
                    r_prod[i] <= r_prod[i-1];
                    r_tag[i]  <= r_tag[i-1];
                    r_sgn[i]  <= r_sgn[i-1];
                end
            end
            case ({w_accept, w_retire})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

endmodule
